// File: rtl/adpll_lock_detector.sv
// ADPLL lock-quality monitor: windowed phase-error qualifier with hysteresis.
// Optional sticky loss flag: define ADPLL_LOCK_LOSS_FLAG_EN.
module adpll_lock_detector #(
    parameter int PDET_WIDTH    = 8,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int TIMEOUT_WIDTH = 12
) (
    input  logic                         fpga_clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic                         ref_i,
    input  logic signed [PDET_WIDTH-1:0] error_i,
    input  logic        [PDET_WIDTH-2:0] threshold_i,
    input  logic                         loss_clr_i,
    output logic                         lock_o,
    output logic        [1:0]            state_o,
    output logic        [PDET_WIDTH-2:0] abs_err_o,
    output logic                         sample_o,
    output logic                         loss_o
);

    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [HW-1:0] HIT_LAST = HW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_COUNT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] T_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACQUIRE  = 2'd1,
        S_LOCKED   = 2'd2,
        S_HOLDOVER = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [HW-1:0]            hit_q, hit_d;
    logic [MW-1:0]            miss_q, miss_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic [PDET_WIDTH-2:0]    abs_q;
    logic                     sync1_q, sync2_q, dly_q;
    logic                     strobe;
    logic [PDET_WIDTH-1:0]    neg_w;
    logic [PDET_WIDTH-2:0]    abs_w;
    logic                     in_win;
    logic                     drop;
    logic                     loss_set;

    // Reference synchroniser plus edge-detect delay flop
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= ref_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign strobe = sync2_q & ~dly_q;

    // Saturating magnitude; only the most negative code stays negative after negation
    always_comb begin
        neg_w = ~error_i + 1'b1;
        abs_w = error_i[PDET_WIDTH-2:0];
        if (error_i[PDET_WIDTH-1]) begin
            if (neg_w[PDET_WIDTH-1]) abs_w = '1;
            else                     abs_w = neg_w[PDET_WIDTH-2:0];
        end
        in_win = (abs_w <= threshold_i);
    end

    // Next state, counters and watchdog; disable overrides everything
    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        drop     = 1'b0;
        loss_set = 1'b0;
        timer_d  = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;
        if (strobe) timer_d = '0;
        if (!enable_i) begin
            state_d = S_IDLE;
            hit_d   = '0;
            miss_d  = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ACQUIRE;
                    hit_d   = '0;
                    miss_d  = '0;
                    timer_d = '0;
                end
                S_ACQUIRE: begin
                    timer_d = '0;
                    if (strobe) begin
                        if (!in_win) begin
                            hit_d = '0;
                        end else if (hit_q == HIT_LAST) begin
                            state_d = S_LOCKED;
                            hit_d   = '0;
                        end else begin
                            hit_d = hit_q + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (strobe) begin
                        if (!in_win) begin
                            if (UNLOCK_COUNT == 1) begin
                                drop = 1'b1;
                            end else begin
                                state_d = S_HOLDOVER;
                                miss_d  = MW'(1);
                            end
                        end
                    end else if (timer_q == T_MAX) begin
                        drop = 1'b1;
                    end
                end
                S_HOLDOVER: begin
                    if (strobe) begin
                        if (in_win) begin
                            state_d = S_LOCKED;
                            miss_d  = '0;
                        end else if (miss_q == MISS_LAST) begin
                            drop = 1'b1;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else if (timer_q == T_MAX) begin
                        drop = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (drop) begin
                state_d  = S_ACQUIRE;
                hit_d    = '0;
                miss_d   = '0;
                timer_d  = '0;
                loss_set = 1'b1;
            end
        end
    end

    // State, counter, timer and captured-magnitude registers
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            hit_q   <= '0;
            miss_q  <= '0;
            timer_q <= '0;
            abs_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            timer_q <= timer_d;
            if (strobe && enable_i) abs_q <= abs_w;
        end
    end

`ifdef ADPLL_LOCK_LOSS_FLAG_EN
    logic loss_q;

    // Sticky loss flag; a new loss event beats a simultaneous clear
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i)        loss_q <= 1'b0;
        else if (loss_set)   loss_q <= 1'b1;
        else if (loss_clr_i) loss_q <= 1'b0;
    end

    assign loss_o = loss_q;
`else
    logic unused_loss;
    assign unused_loss = loss_clr_i ^ loss_set;
    assign loss_o      = 1'b0;
`endif

    assign lock_o    = (state_q == S_LOCKED) || (state_q == S_HOLDOVER);
    assign state_o   = state_q;
    assign abs_err_o = abs_q;
    assign sample_o  = strobe;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Self-checking bench for adpll_lock_detector.
// Loss-flag expectations follow ADPLL_LOCK_LOSS_FLAG_EN.
module tb_adpll_lock_detector;

`ifdef ADPLL_LOCK_LOSS_FLAG_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic              fpga_clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic              enable_i = 1'b0;
    logic              ref_i = 1'b0;
    logic signed [7:0] error_i = '0;
    logic        [6:0] threshold_i = '0;
    logic              loss_clr_i = 1'b0;
    logic              lock_o;
    logic        [1:0] state_o;
    logic        [6:0] abs_err_o;
    logic              sample_o;
    logic              loss_o;

    int n_chk = 0;
    int n_err = 0;

    adpll_lock_detector #(
        .PDET_WIDTH(8), .LOCK_COUNT(16),
        .UNLOCK_COUNT(4), .TIMEOUT_WIDTH(12)
    ) dut (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ref_i      (ref_i),
        .error_i    (error_i),
        .threshold_i(threshold_i),
        .loss_clr_i (loss_clr_i),
        .lock_o     (lock_o),
        .state_o    (state_o),
        .abs_err_o  (abs_err_o),
        .sample_o   (sample_o),
        .loss_o     (loss_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    initial begin
        #2ms;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int err;
        int thr;
        int abs_e;
        int st;
        int lk;
        int ls;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise ref so the strobe lands; return just after the capture edge E2
    task automatic strobe_to_e2(input int err, input int thr);
        @(negedge fpga_clk_i);
        error_i     = 8'(err);
        threshold_i = 7'(thr);
        ref_i       = 1'b1;
        repeat (2) @(posedge fpga_clk_i);
        #1 chk("sample_hi", int'(sample_o), 1);
        @(posedge fpga_clk_i);
        #1 chk("sample_lo", int'(sample_o), 0);
    endtask

    task automatic release_ref;
        @(negedge fpga_clk_i);
        ref_i = 1'b0;
        repeat (3) @(posedge fpga_clk_i);
    endtask

    task automatic sample(input int err, input int thr);
        strobe_to_e2(err, thr);
        release_ref();
    endtask

    task automatic lock_up;
        for (int i = 0; i < 15; i++) sample(0, 3);
        strobe_to_e2(0, 3);
        chk("lock_up_state", int'(state_o), 2);
    endtask

    task automatic clr_loss;
        @(negedge fpga_clk_i);
        loss_clr_i = 1'b1;
        @(posedge fpga_clk_i);
        #1 chk("loss_clr", int'(loss_o), 0);
        @(negedge fpga_clk_i);
        loss_clr_i = 1'b0;
    endtask

    initial begin
        int m_st, m_hit, m_miss, m_loss;
        int thr, err, a;
        bit inw;

        for (int i = 0; i < 15; i++) tbl[i] = '{0, 3, 0, 1, 0, 0};
        tbl[15] = '{0, 3, 0, 2, 1, 0};
        for (int i = 16; i < 19; i++) tbl[i] = '{10, 3, 10, 3, 1, 0};
        tbl[19] = '{0, 3, 0, 2, 1, 0};
        for (int i = 20; i < 23; i++) tbl[i] = '{-10, 3, 10, 3, 1, 0};
        tbl[23] = '{-10, 3, 10, 1, 0, 1};
        tbl[24] = '{-128, 127, 127, 1, 0, 1};
        tbl[25] = '{127, 126, 127, 1, 0, 1};
        tbl[26] = '{-3, 3, 3, 1, 0, 1};

        // reset values
        repeat (2) @(posedge fpga_clk_i);
        #1;
        chk("rst_lock", int'(lock_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_abs", int'(abs_err_o), 0);
        chk("rst_sample", int'(sample_o), 0);
        chk("rst_loss", int'(loss_o), 0);

        @(negedge fpga_clk_i);
        reset_i  = 1'b1;
        enable_i = 1'b1;
        @(posedge fpga_clk_i);
        #1 chk("idle_to_acq", int'(state_o), 1);

        // table-driven main sequence
        foreach (tbl[i]) begin
            strobe_to_e2(tbl[i].err, tbl[i].thr);
            chk($sformatf("tbl%0d_abs", i), int'(abs_err_o), tbl[i].abs_e);
            chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
            chk($sformatf("tbl%0d_lock", i), int'(lock_o), tbl[i].lk);
            chk($sformatf("tbl%0d_loss", i), int'(loss_o), tbl[i].ls * LOSS_EN);
            release_ref();
        end
        clr_loss();

        // watchdog expiry with ref stopped
        sample(100, 3);
        lock_up();
        @(negedge fpga_clk_i);
        ref_i = 1'b0;
        repeat (4095) @(posedge fpga_clk_i);
        #1 chk("wd_before", int'(state_o), 2);
        @(posedge fpga_clk_i);
        #1;
        chk("wd_state", int'(state_o), 1);
        chk("wd_lock", int'(lock_o), 0);
        chk("wd_loss", int'(loss_o), LOSS_EN);
        clr_loss();

        // strobe on the expiry cycle keeps lock
        lock_up();
        @(negedge fpga_clk_i);
        ref_i = 1'b0;
        repeat (4093) @(posedge fpga_clk_i);
        @(negedge fpga_clk_i);
        error_i = '0;
        ref_i   = 1'b1;
        repeat (3) @(posedge fpga_clk_i);
        #1;
        chk("wd_coinc_state", int'(state_o), 2);
        chk("wd_coinc_lock", int'(lock_o), 1);
        release_ref();

        // disable during acquire with a coincident strobe
        @(negedge fpga_clk_i);
        enable_i = 1'b0;
        @(posedge fpga_clk_i);
        #1 chk("dis_state", int'(state_o), 0);
        chk("dis_lock", int'(lock_o), 0);
        @(negedge fpga_clk_i);
        enable_i = 1'b1;
        @(posedge fpga_clk_i);
        #1 chk("reen_state", int'(state_o), 1);
        for (int i = 0; i < 5; i++) sample(0, 3);
        @(negedge fpga_clk_i);
        error_i = '0;
        ref_i   = 1'b1;
        repeat (2) @(posedge fpga_clk_i);
        @(negedge fpga_clk_i);
        enable_i = 1'b0;
        @(posedge fpga_clk_i);
        #1 chk("dis_coinc_state", int'(state_o), 0);
        @(negedge fpga_clk_i);
        ref_i    = 1'b0;
        enable_i = 1'b1;
        repeat (3) @(posedge fpga_clk_i);
        for (int i = 0; i < 15; i++) sample(0, 3);
        chk("hits_cleared", int'(state_o), 1);
        strobe_to_e2(0, 3);
        chk("relock_state", int'(state_o), 2);
        release_ref();

        // async reset while in holdover
        strobe_to_e2(100, 3);
        chk("hold_state", int'(state_o), 3);
        release_ref();
        @(negedge fpga_clk_i);
        #2 reset_i = 1'b0;
        #1;
        chk("arst_lock", int'(lock_o), 0);
        chk("arst_state", int'(state_o), 0);
        chk("arst_abs", int'(abs_err_o), 0);
        chk("arst_sample", int'(sample_o), 0);
        chk("arst_loss", int'(loss_o), 0);
        @(negedge fpga_clk_i);
        reset_i = 1'b1;
        #1 chk("arst_rel_state", int'(state_o), 0);
        @(posedge fpga_clk_i);
        #1 chk("arst_restart", int'(state_o), 1);

        // randomized samples against a sample-level reference model
        m_st = 1;
        m_hit = 0;
        m_miss = 0;
        m_loss = 0;
        for (int n = 0; n < 400; n++) begin
            thr = int'($urandom_range(0, 20));
            if ($urandom_range(0, 99) < 93)
                err = int'($urandom_range(0, 2 * thr)) - thr;
            else
                err = int'($urandom_range(0, 255)) - 128;
            a = (err < 0) ? -err : err;
            if (a > 127) a = 127;
            inw = (a <= thr);
            if (m_st == 1) begin
                m_hit = inw ? m_hit + 1 : 0;
                if (m_hit == 16) begin
                    m_st = 2;
                    m_hit = 0;
                end
            end else if (!inw) begin
                m_miss = m_miss + 1;
                m_st = 3;
                if (m_miss == 4) begin
                    m_st = 1;
                    m_miss = 0;
                    m_hit = 0;
                    m_loss = LOSS_EN;
                end
            end else begin
                m_st = 2;
                m_miss = 0;
            end
            strobe_to_e2(err, thr);
            chk("rnd_abs", int'(abs_err_o), a);
            chk("rnd_state", int'(state_o), m_st);
            chk("rnd_lock", int'(lock_o), (m_st >= 2) ? 1 : 0);
            chk("rnd_loss", int'(loss_o), m_loss);
            release_ref();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
